// File: rtl/addsub_pipe.sv
// Pipelined add/subtract: stage k resolves result slice k from the carry registered by stage k-1.
// Operands ride forward with the carry; sign bits and mode travel along to form the flags at the last stage.
module addsub_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_diff,
  output logic             carry_borrow,
  output logic             overflow,
  output logic             zero
);

  localparam int SLICE = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  logic                          advance;
  logic [WIDTH-1:0]              b_eff;

  logic [STAGES-1:0][WIDTH-1:0]  a_q, a_d;
  logic [STAGES-1:0][WIDTH-1:0]  b_q, b_d;
  logic [STAGES-1:0][WIDTH-1:0]  r_q, r_d;
  logic [STAGES-1:0]             c_q, c_d;
  logic [STAGES-1:0]             m_q, m_d;
  logic [STAGES-1:0]             v_q, v_d;
  logic                          cb_q, cb_d;
  logic                          ovf_q, ovf_d;
  logic                          zero_q, zero_d;

  // Index 0 is the accepted input; index k+1 is the register after stage k.
  logic [STAGES:0][WIDTH-1:0]    a_p, b_p, r_p;
  logic [STAGES:0]               c_p, m_p, v_p;
  logic [SLICE:0]                slice_sum;
  logic                          unused_tail;

  assign advance  = ~v_q[LAST] | out_ready;
  assign in_ready = advance;

  assign b_eff = mode ? ~b : b;
  assign a_p   = {a_q, a};
  assign b_p   = {b_q, b_eff};
  assign r_p   = {r_q, {WIDTH{1'b0}}};
  assign c_p   = {c_q, c_in ^ mode};
  assign m_p   = {m_q, mode};
  assign v_p   = {v_q, in_valid};

  assign unused_tail = ^{a_p[STAGES], b_p[STAGES], c_p[STAGES], m_p[STAGES]};

  always_comb begin
    a_d       = a_p[STAGES-1:0];
    b_d       = b_p[STAGES-1:0];
    r_d       = r_p[STAGES-1:0];
    m_d       = m_p[STAGES-1:0];
    v_d       = v_p[STAGES-1:0];
    c_d       = '0;
    slice_sum = '0;
    for (int k = 0; k < STAGES; k++) begin
      slice_sum = {1'b0, a_p[k][k*SLICE +: SLICE]}
                + {1'b0, b_p[k][k*SLICE +: SLICE]}
                + (SLICE+1)'(c_p[k]);
      r_d[k][k*SLICE +: SLICE] = slice_sum[SLICE-1:0];
      c_d[k] = slice_sum[SLICE];
    end
    // Subtract runs as a + ~b + ~c_in, so its borrow is the inverted carry.
    cb_d   = c_d[LAST] ^ m_d[LAST];
    ovf_d  = (a_d[LAST][WIDTH-1] == b_d[LAST][WIDTH-1]) &&
             (r_d[LAST][WIDTH-1] != a_d[LAST][WIDTH-1]);
    zero_d = (r_d[LAST] == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      r_q    <= '0;
      c_q    <= '0;
      m_q    <= '0;
      v_q    <= '0;
      cb_q   <= 1'b0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else if (advance) begin
      a_q    <= a_d;
      b_q    <= b_d;
      r_q    <= r_d;
      c_q    <= c_d;
      m_q    <= m_d;
      v_q    <= v_d;
      cb_q   <= cb_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
    end
  end

  assign out_valid    = v_q[LAST];
  assign sum_diff     = r_q[LAST];
  assign carry_borrow = cb_q;
  assign overflow     = ovf_q;
  assign zero         = zero_q;

endmodule

// File: tb/tb_addsub_pipe.sv
// Scoreboard bench for addsub_pipe (WIDTH=32, STAGES=4): directed corner cases, stalled stream,
// mid-flight reset and a randomised run with random source gaps and consumer back-pressure.
module tb_addsub_pipe;

  typedef struct {
    logic [31:0] res;
    logic        cb;
    logic        ovf;
    logic        z;
    int          acc;
    bit          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        c_in, mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] sum_diff;
  logic        carry_borrow, overflow, zero;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  exp_t        q[$];
  exp_t        mon_e;
  bit          stall_prev = 1'b0;
  logic [35:0] held;
  bit          rnd_on = 1'b0;

  addsub_pipe #(.WIDTH(32), .STAGES(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a            (a),
    .b            (b),
    .c_in         (c_in),
    .mode         (mode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .sum_diff     (sum_diff),
    .carry_borrow (carry_borrow),
    .overflow     (overflow),
    .zero         (zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [31:0] ta, input logic [31:0] tbv,
                                 input logic tc, input logic tm);
    exp_t        e;
    logic [32:0] full;
    if (!tm) begin
      full  = {1'b0, ta} + {1'b0, tbv} + 33'(tc);
      e.res = full[31:0];
      e.cb  = full[32];
      e.ovf = (ta[31] == tbv[31]) && (e.res[31] != ta[31]);
    end else begin
      e.res = ta - tbv - 32'(tc);
      e.cb  = ({1'b0, ta} < ({1'b0, tbv} + 33'(tc)));
      e.ovf = (ta[31] != tbv[31]) && (e.res[31] != ta[31]);
    end
    e.z   = (e.res == 32'd0);
    e.acc = 0;
    e.lat = 1'b0;
    return e;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_e(input logic [31:0] ta, input logic [31:0] tbv,
                        input logic tc, input logic tm, input exp_t e);
    int waits = 0;
    bit ok    = 1'b1;
    a = ta; b = tbv; c_in = tc; mode = tm; in_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
      if (waits > 200) begin
        check("accept_timeout", 64'(waits), 64'd0);
        ok = 1'b0;
        break;
      end
    end
    if (ok) begin
      e.acc = cyc;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] ta, input logic [31:0] tbv,
                      input logic tc, input logic tm, input bit lat);
    exp_t e;
    e     = model(ta, tbv, tc, tm);
    e.lat = lat;
    send_e(ta, tbv, tc, tm, e);
  endtask

  task automatic send_x(input logic [31:0] ta, input logic [31:0] tbv, input logic tc,
                        input logic tm, input logic [31:0] res, input logic cb,
                        input logic ovf, input logic z);
    exp_t e;
    e.res = res; e.cb = cb; e.ovf = ovf; e.z = z; e.acc = 0; e.lat = 1'b1;
    send_e(ta, tbv, tc, tm, e);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_empty", 64'(q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev)
        check("hold", {28'd0, out_valid, carry_borrow, overflow, zero, sum_diff}, {28'd0, held});
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("spurious_out", {32'd0, sum_diff}, 64'd0);
          check("spurious_valid", 64'(out_valid), 64'd0);
        end else begin
          mon_e = q.pop_front();
          check("sum_diff", {32'd0, sum_diff}, {32'd0, mon_e.res});
          check("carry_borrow", 64'(carry_borrow), 64'(mon_e.cb));
          check("overflow", 64'(overflow), 64'(mon_e.ovf));
          check("zero", 64'(zero), 64'(mon_e.z));
          if (mon_e.lat) check("latency", 64'(cyc - mon_e.acc), 64'd4);
        end
      end
      stall_prev = out_valid && !out_ready;
      held       = {out_valid, carry_borrow, overflow, zero, sum_diff};
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; mode = 1'b0; out_ready = 1'b1;
    #3;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_sum_diff", {32'd0, sum_diff}, 64'd0);
    check("rst_flags", {61'd0, carry_borrow, overflow, zero}, 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;

    // Directed corners, first one presented for the first edge after reset release.
    send_x(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    send_x(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0);
    send_x(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    send_x(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    send_x(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    send_x(32'h0000_0003, 32'h0000_0002, 1'b1, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
    drain();

    // Back-to-back mixed stream with consumer stalled in stream cycles 5-7.
    fork
      begin
        for (int i = 0; i < 8; i++)
          send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'(i % 2), 1'b0);
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          check("stall_in_ready", 64'(in_ready), 64'd0);
          @(posedge clk);
        end
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Asynchronous reset with transactions in flight.
    for (int i = 0; i < 4; i++)
      send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
    check("pre_reset_valid", 64'(out_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_sum", {32'd0, sum_diff}, 64'd0);
    check("async_rst_flags", {61'd0, carry_borrow, overflow, zero}, 64'd0);
    check("async_rst_in_ready", 64'(in_ready), 64'd1);
    q.delete();
    @(posedge clk);
    #3 rst_n = 1'b1;
    send(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, 1'b1);
    repeat (10) @(posedge clk);
    #1;
    check("post_reset_drained", 64'(q.size()), 64'd0);

    // Randomised traffic with source gaps and random back-pressure.
    rnd_on = 1'b1;
    fork
      while (rnd_on) begin
        @(posedge clk);
        #1;
        if (rnd_on) out_ready = ($urandom_range(0, 3) != 0);
      end
    join_none
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ra, rb;
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: ra = 32'h0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = ra;
        3: ra = 32'h8000_0000;
        default: ;
      endcase
      send(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    rnd_on    = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
